// File: rtl/wave_gen_dds.sv
// wave_gen_dds: DDS waveform generator (phase accumulator, four-mode shaper,
// optional amplitude scaler) feeding DAC sample registers directly.
// Optional feature macro: WAVE_GEN_AMP_EN builds the amplitude multiplier and
// its pending/active amp registers; without it dout is the shaper output.
// Configuration is double-buffered and committed only at phase wrap, on
// sync_clr, or whenever the generator is stopped (active ftw of zero).
module wave_gen_dds #(
  parameter int PHASE_W = 32,
  parameter int DATA_W  = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ce,
  input  logic               sync_clr,
  input  logic               cfg_load,
  input  logic [PHASE_W-1:0] ftw,
  input  logic [PHASE_W-1:0] phase_off,
  input  logic [1:0]         mode,
  input  logic [DATA_W-1:0]  duty,
  input  logic [DATA_W-1:0]  amp,
  output logic [DATA_W-1:0]  dout,
  output logic               dout_valid,
  output logic               wrap
);

  typedef enum logic [1:0] {
    MODE_SAW_UP   = 2'd0,
    MODE_SAW_DOWN = 2'd1,
    MODE_TRIANGLE = 2'd2,
    MODE_SQUARE   = 2'd3
  } wave_mode_t;

  localparam logic [DATA_W-1:0] MAX_LEVEL  = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] DUTY_RESET = {1'b1, {(DATA_W-1){1'b0}}};

  // Stage 0 state
  logic [PHASE_W-1:0] acc;

  // Pending and active configuration sets
  logic [PHASE_W-1:0] ftw_pend, ftw_act;
  logic [PHASE_W-1:0] off_pend, off_act;
  wave_mode_t         mode_pend, mode_act;
  logic [DATA_W-1:0]  duty_pend, duty_act;
  logic               pending_flag;

  // Accumulator arithmetic and commit decision
  logic [PHASE_W-1:0] acc_sum;
  logic               acc_carry;
  logic               carry;
  logic               commit;

  // Stage 1 signals
  logic [DATA_W-1:0]         phase;
  logic [PHASE_W-DATA_W-1:0] phase_frac_unused;
  logic [DATA_W-1:0]         tri_ramp;
  logic [DATA_W-1:0]         shape_w;
  logic [DATA_W-1:0]         shape_q;
  logic                      ce_d1;

  // Advance sum, its carry, and whether this edge commits the pending set
  always_comb begin
    acc_carry = 1'b0;
    acc_sum   = '0;
    carry     = 1'b0;
    commit    = 1'b0;
    {acc_carry, acc_sum} = {1'b0, acc} + {1'b0, ftw_act};
    carry  = ce & ~sync_clr & acc_carry;
    commit = carry | sync_clr | (ftw_act == '0);
  end

  // Phase accumulator: sync_clr beats ce, wrap flags the post-carry value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc  <= '0;
      wrap <= 1'b0;
    end else begin
      if (sync_clr) begin
        acc <= '0;
      end else if (ce) begin
        acc <= acc_sum;
      end
      wrap <= carry;
    end
  end

  // Pending set captures every cfg_load; the flag marks an uncommitted set
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ftw_pend     <= '0;
      off_pend     <= '0;
      mode_pend    <= MODE_SAW_UP;
      duty_pend    <= DUTY_RESET;
      pending_flag <= 1'b0;
    end else begin
      if (cfg_load) begin
        ftw_pend  <= ftw;
        off_pend  <= phase_off;
        mode_pend <= wave_mode_t'(mode);
        duty_pend <= duty;
      end
      if (commit) begin
        pending_flag <= 1'b0;
      end else if (cfg_load) begin
        pending_flag <= 1'b1;
      end
    end
  end

  // Active set: a load coinciding with a commit bypasses the pending set
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ftw_act  <= '0;
      off_act  <= '0;
      mode_act <= MODE_SAW_UP;
      duty_act <= DUTY_RESET;
    end else if (commit && cfg_load) begin
      ftw_act  <= ftw;
      off_act  <= phase_off;
      mode_act <= wave_mode_t'(mode);
      duty_act <= duty;
    end else if (commit && pending_flag) begin
      ftw_act  <= ftw_pend;
      off_act  <= off_pend;
      mode_act <= mode_pend;
      duty_act <= duty_pend;
    end
  end

  // Offset phase; only the top DATA_W bits address the waveform
  assign {phase, phase_frac_unused} = acc + off_act;

  // Waveform shaper for the active mode
  always_comb begin
    tri_ramp = {phase[DATA_W-2:0], 1'b0};
    shape_w  = '0;
    case (mode_act)
      MODE_SAW_UP:   shape_w = phase;
      MODE_SAW_DOWN: shape_w = ~phase;
      MODE_TRIANGLE: shape_w = phase[DATA_W-1] ? ~tri_ramp : tri_ramp;
      MODE_SQUARE:   shape_w = (phase < duty_act) ? MAX_LEVEL : '0;
      default:       shape_w = '0;
    endcase
  end

  // Stage 1 register: shaped sample and the first ce delay
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shape_q <= '0;
      ce_d1   <= 1'b0;
    end else begin
      shape_q <= shape_w;
      ce_d1   <= ce;
    end
  end

`ifdef WAVE_GEN_AMP_EN
  logic [DATA_W-1:0] amp_pend, amp_act, amp_q;
  logic [DATA_W:0]   amp_scale;
  logic [2*DATA_W:0] product;
  logic              product_top_unused;
  logic [DATA_W-1:0] product_low_unused;
  logic [DATA_W-1:0] scaled;

  // Amplitude follows the same pending/active commit rules as the rest
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      amp_pend <= MAX_LEVEL;
      amp_act  <= MAX_LEVEL;
    end else begin
      if (cfg_load) begin
        amp_pend <= amp;
      end
      if (commit && cfg_load) begin
        amp_act <= amp;
      end else if (commit && pending_flag) begin
        amp_act <= amp_pend;
      end
    end
  end

  // Amplitude travels with its sample so config stays coherent per sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      amp_q <= MAX_LEVEL;
    end else begin
      amp_q <= amp_act;
    end
  end

  // Scale by (amp+1)/2^DATA_W so amp of all ones is an exact pass-through
  assign amp_scale = {1'b0, amp_q} + {{DATA_W{1'b0}}, 1'b1};
  assign product   = {{(DATA_W+1){1'b0}}, shape_q} * {{DATA_W{1'b0}}, amp_scale};
  assign {product_top_unused, scaled, product_low_unused} = product;

  // Stage 2 register: scaled sample and the second ce delay
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout       <= scaled;
      dout_valid <= ce_d1;
    end
  end
`else
  logic [DATA_W-1:0] amp_unused;
  assign amp_unused = amp;

  // Stage 2 register: plain copy of the shaped sample, same latency
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout       <= shape_q;
      dout_valid <= ce_d1;
    end
  end
`endif

endmodule

// File: tb/tb_wave_gen_dds.sv
// tb_wave_gen_dds: scoreboard bench for wave_gen_dds at PHASE_W=16, DATA_W=8.
module tb_wave_gen_dds;

  logic        clk;
  logic        reset_n;
  logic        ce;
  logic        sync_clr;
  logic        cfg_load;
  logic [15:0] ftw;
  logic [15:0] phase_off;
  logic [1:0]  mode;
  logic [7:0]  duty;
  logic [7:0]  amp;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        wrap;

  int tests_run;
  int tests_failed;

  typedef struct packed {
    logic [7:0] dout;
    logic       valid;
  } sample_t;

  sample_t sb[$];
  sample_t exp_s;
  logic    exp_wrap;

  // Reference model state (accumulator plus active/pending configuration)
  logic [15:0] m_acc;
  logic [15:0] a_ftw, a_off, p_ftw, p_off;
  logic [1:0]  a_mode, p_mode;
  logic [7:0]  a_duty, a_amp, p_duty, p_amp;

`ifdef WAVE_GEN_AMP_EN
  localparam logic [7:0] SQ_HI_7F = 8'h7F;
`else
  localparam logic [7:0] SQ_HI_7F = 8'hFF;
`endif

  wave_gen_dds #(.PHASE_W(16), .DATA_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ce         (ce),
    .sync_clr   (sync_clr),
    .cfg_load   (cfg_load),
    .ftw        (ftw),
    .phase_off  (phase_off),
    .mode       (mode),
    .duty       (duty),
    .amp        (amp),
    .dout       (dout),
    .dout_valid (dout_valid),
    .wrap       (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [7:0] model_sample();
    logic [15:0] s;
    int p;
    int w;
    s = m_acc + a_off;
    p = int'(s[15:8]);
    case (a_mode)
      2'd0:    w = p;
      2'd1:    w = 255 - p;
      2'd2:    w = (p < 128) ? 2 * p : 255 - 2 * (p - 128);
      default: w = (p < int'(a_duty)) ? 255 : 0;
    endcase
`ifdef WAVE_GEN_AMP_EN
    w = (w * (int'(a_amp) + 1)) / 256;
`endif
    return w[7:0];
  endfunction

  task automatic model_reset();
    m_acc  = '0;
    a_ftw  = '0;    p_ftw  = '0;
    a_off  = '0;    p_off  = '0;
    a_mode = 2'd0;  p_mode = 2'd0;
    a_duty = 8'h80; p_duty = 8'h80;
    a_amp  = 8'hFF; p_amp  = 8'hFF;
    exp_wrap = 1'b0;
    sb.delete();
    sb.push_back('{dout: 8'h00, valid: 1'b0});
  endtask

  // Advance model and DUT by one edge; exp_s/exp_wrap describe the new outputs
  task automatic tick();
    sample_t s;
    logic [16:0] sum;
    logic carry, commit;
    s.dout  = model_sample();
    s.valid = ce;
    sum    = {1'b0, m_acc} + {1'b0, a_ftw};
    carry  = ce && !sync_clr && sum[16];
    commit = carry || sync_clr || (a_ftw == 16'h0000);
    if (sync_clr) m_acc = '0;
    else if (ce) m_acc = sum[15:0];
    if (commit) begin
      if (cfg_load) begin
        a_ftw = ftw; a_off = phase_off; a_mode = mode; a_duty = duty; a_amp = amp;
      end else begin
        a_ftw = p_ftw; a_off = p_off; a_mode = p_mode; a_duty = p_duty; a_amp = p_amp;
      end
    end
    if (cfg_load) begin
      p_ftw = ftw; p_off = phase_off; p_mode = mode; p_duty = duty; p_amp = amp;
    end
    @(posedge clk);
    #1;
    exp_wrap = carry;
    if (sb.size() > 0) exp_s = sb.pop_front();
    sb.push_back(s);
  endtask

  task automatic wait_wrap(input int limit, output logic found);
    found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      tick();
      if (wrap === 1'b1) found = 1'b1;
    end
  endtask

  task automatic drive_cfg(input logic [15:0] f, input logic [15:0] o,
                           input logic [1:0] md, input logic [7:0] dt, input logic [7:0] am);
    ftw = f; phase_off = o; mode = md; duty = dt; amp = am;
    cfg_load = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ce = 1'b0; sync_clr = 1'b0; cfg_load = 1'b0;
    ftw = '0; phase_off = '0; mode = 2'd0; duty = 8'h80; amp = 8'hFF;
    model_reset();
    #17;
    tests_run++;
    if (dout !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_dout: got %02h want 00", dout); end
    tests_run++;
    if (dout_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %0b want 0", dout_valid); end
    tests_run++;
    if (wrap !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_wrap: got %0b want 0", wrap); end
    #3 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++;
      if (dout !== exp_s.dout || dout_valid !== exp_s.valid || wrap !== exp_wrap) begin
        tests_failed++;
        $display("[TB] FAIL idle_sb: got %02h/%0b/%0b want %02h/%0b/%0b", dout, dout_valid, wrap, exp_s.dout, exp_s.valid, exp_wrap);
      end
    end
  endtask

  task automatic test_saw_up();
    int last_wrap;
    int n_wraps;
    logic [1:0] hist;
    last_wrap = -1; n_wraps = 0; hist = 2'b00;
    ce = 1'b1;
    drive_cfg(16'h0100, 16'h0000, 2'd0, 8'h80, 8'hFF);
    tick();
    cfg_load = 1'b0;
    for (int i = 0; i < 600; i++) begin
      tick();
      tests_run++;
      if (dout !== exp_s.dout || dout_valid !== exp_s.valid || wrap !== exp_wrap) begin
        tests_failed++;
        $display("[TB] FAIL saw_up_sb: got %02h/%0b/%0b want %02h/%0b/%0b", dout, dout_valid, wrap, exp_s.dout, exp_s.valid, exp_wrap);
      end
      if (hist[1]) begin
        tests_run++;
        if (dout !== 8'h00) begin tests_failed++; $display("[TB] FAIL saw_up_zero_after_wrap: got %02h want 00", dout); end
      end
      if (wrap === 1'b1) begin
        if (last_wrap >= 0) begin
          tests_run++;
          if (i - last_wrap != 256) begin tests_failed++; $display("[TB] FAIL saw_up_wrap_period: got %0d want 256", i - last_wrap); end
        end
        last_wrap = i;
        n_wraps++;
      end
      hist = {hist[0], wrap};
    end
    tests_run++;
    if (n_wraps < 2) begin tests_failed++; $display("[TB] FAIL saw_up_wrap_count: got %0d want >=2", n_wraps); end
  endtask

  task automatic test_triangle_saw_down();
    logic found;
    logic [7:0] want;
    for (int m = 0; m < 2; m++) begin
      drive_cfg(16'h0100, 16'h0000, (m == 0) ? 2'd2 : 2'd1, 8'h80, 8'hFF);
      tick();
      cfg_load = 1'b0;
      wait_wrap(600, found);
      tests_run++;
      if (!found) begin tests_failed++; $display("[TB] FAIL shape_wrap_timeout: got no wrap want wrap"); end
      tick();
      tick();
      for (int i = 0; i < 256; i++) begin
        if (m == 0) want = (i < 128) ? 8'(2 * i) : 8'(2 * (255 - i) + 1);
        else        want = 8'(255 - i);
        tests_run++;
        if (dout !== want) begin tests_failed++; $display("[TB] FAIL shape_mode%0d_sample%0d: got %02h want %02h", (m == 0) ? 2 : 1, i, dout, want); end
        tests_run++;
        if (dout !== exp_s.dout || wrap !== exp_wrap) begin
          tests_failed++;
          $display("[TB] FAIL shape_sb: got %02h/%0b want %02h/%0b", dout, wrap, exp_s.dout, exp_wrap);
        end
        tick();
      end
    end
  endtask

  task automatic test_square_amp();
    logic found;
    logic [7:0] want;
    for (int k = 0; k < 2; k++) begin
      drive_cfg(16'h0100, 16'h0000, 2'd3, 8'h40, (k == 0) ? 8'h7F : 8'hFF);
      tick();
      cfg_load = 1'b0;
      wait_wrap(600, found);
      tests_run++;
      if (!found) begin tests_failed++; $display("[TB] FAIL square_wrap_timeout: got no wrap want wrap"); end
      tick();
      tick();
      for (int i = 0; i < 256; i++) begin
        want = (i < 64) ? ((k == 0) ? SQ_HI_7F : 8'hFF) : 8'h00;
        tests_run++;
        if (dout !== want) begin tests_failed++; $display("[TB] FAIL square_amp%0d_sample%0d: got %02h want %02h", k, i, dout, want); end
        tests_run++;
        if (dout !== exp_s.dout || dout_valid !== exp_s.valid) begin
          tests_failed++;
          $display("[TB] FAIL square_sb: got %02h/%0b want %02h/%0b", dout, dout_valid, exp_s.dout, exp_s.valid);
        end
        tick();
      end
    end
  endtask

  task automatic test_glitch_free_commit();
    logic found;
    int n;
    drive_cfg(16'h0100, 16'h0000, 2'd0, 8'h80, 8'hFF);
    tick();
    cfg_load = 1'b0;
    wait_wrap(600, found);
    tests_run++;
    if (!found) begin tests_failed++; $display("[TB] FAIL glitch_wrap_timeout: got no wrap want wrap"); end
    for (int i = 0; i < 128; i++) tick();
    drive_cfg(16'h0200, 16'h0000, 2'd0, 8'h80, 8'hFF);
    tick();
    cfg_load = 1'b0;
    n = 1;
    found = 1'b0;
    while (!found && n < 300) begin
      tick();
      n++;
      if (wrap === 1'b1) found = 1'b1;
    end
    tests_run++;
    if (n != 128) begin tests_failed++; $display("[TB] FAIL glitch_step_until_wrap: got %0d cycles want 128", n); end
    tick();
    tick();
    tests_run++;
    if (dout !== 8'h00) begin tests_failed++; $display("[TB] FAIL glitch_first_new: got %02h want 00", dout); end
    tick();
    tests_run++;
    if (dout !== 8'h02) begin tests_failed++; $display("[TB] FAIL glitch_step2: got %02h want 02", dout); end
    for (int i = 0; i < 124; i++) begin
      tick();
      tests_run++;
      if (dout !== exp_s.dout || wrap !== exp_wrap) begin
        tests_failed++;
        $display("[TB] FAIL glitch_sb: got %02h/%0b want %02h/%0b", dout, wrap, exp_s.dout, exp_wrap);
      end
    end
    drive_cfg(16'h0100, 16'h0000, 2'd1, 8'h80, 8'hFF);
    tick();
    cfg_load = 1'b0;
    tests_run++;
    if (wrap !== 1'b1) begin tests_failed++; $display("[TB] FAIL load_on_wrap_pulse: got %0b want 1", wrap); end
    tick();
    tick();
    tests_run++;
    if (dout !== 8'hFF) begin tests_failed++; $display("[TB] FAIL load_on_wrap_first: got %02h want ff", dout); end
    tick();
    tests_run++;
    if (dout !== 8'hFE) begin tests_failed++; $display("[TB] FAIL load_on_wrap_second: got %02h want fe", dout); end
  endtask

  task automatic test_sync_clr_offset();
    logic [7:0] held;
    drive_cfg(16'h0100, 16'h8000, 2'd0, 8'h80, 8'hFF);
    tick();
    cfg_load = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      tests_run++;
      if (dout !== exp_s.dout || wrap !== exp_wrap) begin
        tests_failed++;
        $display("[TB] FAIL sync_pre_sb: got %02h/%0b want %02h/%0b", dout, wrap, exp_s.dout, exp_wrap);
      end
    end
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
    tests_run++;
    if (wrap !== 1'b0) begin tests_failed++; $display("[TB] FAIL sync_no_wrap: got %0b want 0", wrap); end
    tick();
    tick();
    tests_run++;
    if (dout !== 8'h80) begin tests_failed++; $display("[TB] FAIL sync_offset_dout: got %02h want 80", dout); end
    for (int i = 0; i < 10; i++) begin
      tick();
      tests_run++;
      if (dout !== exp_s.dout || dout_valid !== exp_s.valid || wrap !== exp_wrap) begin
        tests_failed++;
        $display("[TB] FAIL sync_post_sb: got %02h/%0b/%0b want %02h/%0b/%0b", dout, dout_valid, wrap, exp_s.dout, exp_s.valid, exp_wrap);
      end
    end
    ce = 1'b0;
    tick();
    tests_run++;
    if (dout_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL ce_off_valid_d1: got %0b want 1", dout_valid); end
    tick();
    tests_run++;
    if (dout_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL ce_off_valid_d2: got %0b want 0", dout_valid); end
    tick();
    held = dout;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++;
      if (dout !== held || dout !== exp_s.dout || wrap !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL ce_off_frozen: got %02h/%0b want %02h/0", dout, wrap, held);
      end
    end
  endtask

  task automatic test_reset_mid_ramp();
    ce = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      tests_run++;
      if (dout !== exp_s.dout || dout_valid !== exp_s.valid || wrap !== exp_wrap) begin
        tests_failed++;
        $display("[TB] FAIL ramp_sb: got %02h/%0b/%0b want %02h/%0b/%0b", dout, dout_valid, wrap, exp_s.dout, exp_s.valid, exp_wrap);
      end
    end
    #3 reset_n = 1'b0;
    #1;
    tests_run++;
    if (dout !== 8'h00 || dout_valid !== 1'b0 || wrap !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset_outputs: got %02h/%0b/%0b want 00/0/0", dout, dout_valid, wrap);
    end
    model_reset();
    #10 reset_n = 1'b1;
    drive_cfg(16'h0100, 16'h0000, 2'd0, 8'h80, 8'hFF);
    tick();
    cfg_load = 1'b0;
    tests_run++;
    if (dout_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL release_valid_low: got %0b want 0", dout_valid); end
    tick();
    tick();
    tests_run++;
    if (dout !== 8'h00) begin tests_failed++; $display("[TB] FAIL release_first: got %02h want 00", dout); end
    tick();
    tests_run++;
    if (dout !== 8'h01) begin tests_failed++; $display("[TB] FAIL release_commit_now: got %02h want 01", dout); end
    for (int i = 0; i < 8; i++) begin
      tick();
      tests_run++;
      if (dout !== exp_s.dout || dout_valid !== exp_s.valid || wrap !== exp_wrap) begin
        tests_failed++;
        $display("[TB] FAIL release_sb: got %02h/%0b/%0b want %02h/%0b/%0b", dout, dout_valid, wrap, exp_s.dout, exp_s.valid, exp_wrap);
      end
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_saw_up();
    test_triangle_saw_down();
    test_square_amp();
    test_glitch_free_commit();
    test_sync_clr_offset();
    test_reset_mid_ramp();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/wave_gen_dds.md
# wave_gen_dds

Parametrised DDS waveform generator that supersedes the fixed 2048×8 sawtooth ROM table in the ADDA path. A phase accumulator drives an arithmetic waveform shaper with four modes: rising saw, falling saw, triangle, and square with programmable duty. An optional amplitude scaler follows the shaper. The block feeds DAC sample registers directly. Configuration is double-buffered and committed glitch-free at phase wrap.

## Interface
- PHASE_W, 32, accumulator width (≥ DATA_W+1)
- DATA_W, 8, sample width (≥ 4)
- clk  in  1  sample clock, all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- ce  in  1  accumulator advance enable
- sync_clr  in  1  synchronous phase clear, one-cycle pulse
- cfg_load  in  1  strobe: latch cfg inputs into pending set
- ftw  in  PHASE_W  frequency tuning word
- phase_off  in  PHASE_W  phase offset
- mode  in  2  0 saw-up, 1 saw-down, 2 triangle, 3 square
- duty  in  DATA_W  square threshold
- amp  in  DATA_W  amplitude; full scale is all ones
- dout  out  DATA_W  sample
- dout_valid  out  1  sample qualifier
- wrap  out  1  one-cycle pulse at accumulator carry-out

## Operation
- Reset: acc=0. Active and pending ftw=0, off=0, mode=0, duty=2^(DATA_W-1), amp=all ones. pending_flag=0; dout=0, dout_valid=0, wrap=0.
- Accumulator: when ce=1, acc <= (acc + ftw_act) mod 2^PHASE_W. carry = carry-out of that sum while ce=1. wrap <= carry.
- Phase: P = top DATA_W bits of (acc + off_act) mod 2^PHASE_W. MAX = 2^DATA_W-1.
- Shaper: mode0 w=P; mode1 w=~P; mode2 T={P[DATA_W-2:0],0}, w = P[MSB] ? ~T : T; mode3 w = (P < duty_act) ? MAX : 0.
- Amplitude: dout = (w·(amp_act+1)) >> DATA_W, truncated. amp=MAX gives exact pass-through.
- Config commit:
  - cfg_load=1 copies all cfg inputs into the pending set and sets pending_flag.
  - Pending moves to active and pending_flag clears on a carry cycle, on sync_clr, or on any cycle where ftw_act=0.
- Simultaneous cfg_load and commit event: the incoming inputs go straight to active, and pending_flag clears.
- sync_clr: acc <= 0 regardless of ce, with pending commit as above. wrap does not pulse. Pipeline contents are not flushed.
- sync_clr and ce together: sync_clr wins.
- Pipeline stages (shaper, amplitude) run every cycle regardless of ce. With ce=0, dout holds a constant value.

## Timing
- Stage 0: acc register.
- Stage 1: phase add, then shaper register.
- Stage 2: amplitude register driving dout.
- Latency: dout at cycle n+2 reflects acc and active config at cycle n.
- dout_valid = ce delayed 2 cycles. It is 0 for the first 2 cycles after reset release.
- Active config changes only at cycle boundaries, so a sample never mixes old and new fields.
- wrap is asserted in the cycle where acc holds the post-carry value. It leads the corresponding dout by 2 cycles.
- Asynchronous reset mid-operation: all registers clear immediately, including pending_flag.

## Configuration
- WAVE_GEN_AMP_EN defined: amplitude multiplier is present; amp and pending/active amp registers are implemented.
- WAVE_GEN_AMP_EN undefined: amp input is ignored and no multiplier is built. Stage 2 is a plain register of w, dout = w, and latency is unchanged.

## Test plan
All scenarios use PHASE_W=16, DATA_W=8, WAVE_GEN_AMP_EN defined.
- Saw-up: cfg_load ftw=0x0100, mode=0, ce=1 -> dout = 0,1,2,…,255,0. wrap pulses every 256 cycles, and dout=0 two cycles after each pulse.
- Triangle/saw-down: ftw=0x0100, mode=2 -> dout 0,2,…,254,255,253,…,1.
  - mode=1 -> dout 255,254,….
- Square and amplitude: mode=3, duty=0x40, amp=0x7F, ftw=0x0100 -> dout = 0x7F for 64 samples, then 0 for 192 samples.
  - amp=0xFF -> high level = 0xFF.
- Glitch-free commit: running ftw=0x0100, cfg_load ftw=0x0200 at P=0x80 -> step stays 1 until the wrap, then becomes 2.
  - Second cfg_load on the exact wrap cycle -> its values take effect at that wrap.
- sync_clr and offset: phase_off=0x8000, mode=0, sync_clr mid-ramp -> acc=0, and dout=0x80 two cycles later with no wrap pulse.
  - ce=0 -> dout frozen and dout_valid falls 2 cycles later.
- Reset mid-ramp: drop reset_n asynchronously -> dout, wrap, and dout_valid are 0 the same cycle.
  - After release with ftw_act=0 and a cfg_load -> the config commits immediately.
